alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle execute unit that consumes the decoded control bundle (`opSwitch`, `isLog`, `dir`, `flagSwitch`) produced by the ALU control decoder and performs the operation on two 32-bit operands. Single-cycle ops (add, complement, and, xor) finish in one cycle. Shifts run one bit per cycle through an internal shift register, which avoids a full barrel shifter. The block holds the architectural carry/zero/sign flags consumed by branch logic, and talks to the datapath sequencer through a start/busy/done handshake.

## Interface
- `WIDTH`, 32, operand/result width
- `SHAMT_W`, 5, shift-amount width; must equal log2(`WIDTH`)

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request; operands and controls are sampled on the edge where `start`=1 and `busy`=0
- `opSwitch`  in  3  0 ADD, 1 COMP, 2 AND, 3 XOR, 4 SHIFT, 5–7 reserved
- `isLog`  in  1  shift type: 1 logical, 0 arithmetic (arithmetic applies to right shifts only)
- `dir`  in  1  shift direction: 0 left, 1 right
- `flagSwitch`  in  3  flag update enables: bit0 carry, bit1 zero, bit2 sign
- `srcA`  in  `WIDTH`  operand A; the value that is shifted
- `srcB`  in  `WIDTH`  operand B; for SHIFT, the shift amount is `srcB[SHAMT_W-1:0]`
- `result`  out  `WIDTH`  registered result; holds until the next `done`
- `done`  out  1  one-cycle pulse; `result` and flags are valid in the same cycle
- `busy`  out  1  high from the accepting edge until the `done` edge
- `carry`, `zero`, `sign`  out  1 each  architectural flags

## Operation
- FSM states:
  - IDLE: accepts `start`.
  - SHIFT: a down-counter loaded with the shift amount; one bit shifted per edge.
  - FIN: one-edge completion state.
- IDLE with `start` and op≠SHIFT:
  - The result is computed and registered into the FIN path.
  - `done` rises on the next edge.
- IDLE with `start` and op=SHIFT:
  - Shift register ← `srcA`; counter ← shift amount; go to SHIFT.
  - If the shift amount is 0, go straight to FIN.
- SHIFT, each edge:
  - Shift one bit: left inserts 0; logical right inserts 0; arithmetic right inserts the MSB.
  - Record the bit shifted out.
  - Decrement the counter; go to FIN when the counter reaches 0.
- FIN: `result` ← computed value, flags updated, `done`=1, `busy`=0, return to IDLE.
- Operation results (all arithmetic modulo 2^`WIDTH`):
  - ADD: `srcA`+`srcB`; carry = carry-out of bit `WIDTH`-1.
  - COMP: ~`srcB`+1; carry = 1 only if `srcB`==0.
  - AND, XOR: bitwise; carry = 0.
  - SHIFT: carry = last bit shifted out; 0 when the shift amount is 0.
  - Reserved opcodes: result = `srcA`, carry = 0.
- Flag update at the `done` edge, each only if its `flagSwitch` bit was 1 at start:
  - carry as defined above
  - zero = (result==0)
  - sign = result[`WIDTH`-1]
  - Flags with a 0 enable bit hold their value.
- Controls and operands are captured at start; input changes during `busy` have no effect.
- `start` while `busy`=1 is ignored entirely: no queueing, no error.
- `start` in the same cycle as `done` is ignored. The sequencer must wait until `busy`=0 and `done`=0.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE; `result`=0; `done`=0; `busy`=0; `carry`=`zero`=`sign`=0; counter and shift register 0.
- Reset mid-operation aborts immediately. No `done` is issued, and flags are not updated by the aborted op.
- Latency is counted in edges from the accepting edge to the `done` edge:
  - Non-shift ops: 1
  - SHIFT with amount n: n+1 (1..32)
- `busy`=1 for exactly latency−1 cycles after the accepting edge. For non-shift ops `busy` never rises.
- Back-to-back throughput: a new `start` can be accepted in the cycle after `done`.

## Test plan
- ADD, `srcA`=0xFFFFFFFF, `srcB`=1, `flagSwitch`=3'b111 → `done` 1 cycle later; `result`=0, carry=1, zero=1, sign=0.
- Arithmetic right shift, `srcA`=0x80000010, `srcB`=5, `isLog`=0, `dir`=1, flags all enabled → `done` after 6 edges; `busy` high 5 cycles; `result`=0xFC000000, carry=1, sign=1, zero=0.
- Logical left shift, `srcA`=3, `srcB`=31, `dir`=0 → `done` after 32 edges; `result`=0x80000000, carry=1. Then shift amount 0 → `done` after 1 edge, `result`=`srcA`, carry=0.
- COMP, `srcB`=0, `flagSwitch`=3'b010, prior flags carry=1, sign=1 → `result`=0, zero=1, carry and sign unchanged. Repeat with `srcB`=5 and `flagSwitch`=3'b101 → `result`=0xFFFFFFFB, sign=1, carry=0.
- Pulse `start` with AND during a 20-bit shift → ignored; only the shift's `done` fires and its result is correct.
- Assert `reset` low during a 10-bit shift → all outputs 0 immediately, no `done`. After release, XOR 0xF0F0F0F0 ^ 0xFF00FF00 → 0x0FF00FF0 after 1 cycle.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Sequencer <-> execute-unit bus: start/busy/done handshake, decoded controls, operands and flags.
interface alu_exec_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       opSwitch;
    logic             isLog;
    logic             dir;
    logic [2:0]       flagSwitch;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic [WIDTH-1:0] result;
    logic             done;
    logic             busy;
    logic             carry;
    logic             zero;
    logic             sign;

    modport master (
        output start, opSwitch, isLog, dir, flagSwitch, srcA, srcB,
        input  result, done, busy, carry, zero, sign
    );

    modport slave (
        input  start, opSwitch, isLog, dir, flagSwitch, srcA, srcB,
        output result, done, busy, carry, zero, sign
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute unit: single-cycle logic/arith ops, bit-serial shifter, architectural flags.
module alu_exec_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    alu_exec_unit_if.slave bus
);
    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_COMP  = 3'd1;
    localparam logic [2:0] OP_AND   = 3'd2;
    localparam logic [2:0] OP_XOR   = 3'd3;
    localparam logic [2:0] OP_SHIFT = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } stateT;

    stateT              state;
    stateT              stateNext;

    logic [WIDTH-1:0]   shReg;
    logic [SHAMT_W-1:0] count;
    logic               lastOut;
    logic               isLogReg;
    logic               dirReg;
    logic [2:0]         flagEn;

    logic [WIDTH-1:0]   resultReg;
    logic               doneReg;
    logic               busyReg;
    logic               carryReg;
    logic               zeroReg;
    logic               signReg;

    logic [WIDTH-1:0]   resultNext;
    logic               doneNext;
    logic               busyNext;
    logic               carryNext;
    logic               zeroNext;
    logic               signNext;

    logic               accept;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   opResult;
    logic               opCarry;
    logic [WIDTH-1:0]   shNext;
    logic               shOut;

    // A start coinciding with the done pulse is dropped; only a quiet IDLE accepts.
    assign accept = (state == IDLE) && bus.start && !doneReg;
    assign shamt  = bus.srcB[SHAMT_W-1:0];

    // Single-cycle ops; also provides the pass-through value that seeds the shifter.
    always_comb begin
        opResult = bus.srcA;
        opCarry  = 1'b0;
        case (bus.opSwitch)
            OP_ADD:  {opCarry, opResult} = {1'b0, bus.srcA} + {1'b0, bus.srcB};
            OP_COMP: begin
                opResult = ~bus.srcB + WIDTH'(1);
                opCarry  = (bus.srcB == '0);
            end
            OP_AND:  opResult = bus.srcA & bus.srcB;
            OP_XOR:  opResult = bus.srcA ^ bus.srcB;
            default: begin
                opResult = bus.srcA;
                opCarry  = 1'b0;
            end
        endcase
    end

    // One-bit shift step; arithmetic right replicates the MSB.
    always_comb begin
        if (dirReg) begin
            shNext = {(!isLogReg) & shReg[WIDTH-1], shReg[WIDTH-1:1]};
            shOut  = shReg[0];
        end else begin
            shNext = {shReg[WIDTH-2:0], 1'b0};
            shOut  = shReg[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = ((bus.opSwitch == OP_SHIFT) && (shamt != '0)) ? SHIFT : FIN;
                end
            end
            SHIFT: begin
                if (count == SHAMT_W'(1)) begin
                    stateNext = FIN;
                end
            end
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output values for the next edge; result and flags only change on completion.
    always_comb begin
        doneNext   = 1'b0;
        busyNext   = (stateNext == SHIFT);
        resultNext = resultReg;
        carryNext  = carryReg;
        zeroNext   = zeroReg;
        signNext   = signReg;
        if (state == FIN) begin
            doneNext   = 1'b1;
            resultNext = shReg;
            if (flagEn[0]) carryNext = lastOut;
            if (flagEn[1]) zeroNext  = (shReg == '0);
            if (flagEn[2]) signNext  = shReg[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resultReg <= '0;
            doneReg   <= 1'b0;
            busyReg   <= 1'b0;
            carryReg  <= 1'b0;
            zeroReg   <= 1'b0;
            signReg   <= 1'b0;
            shReg     <= '0;
            count     <= '0;
            lastOut   <= 1'b0;
            isLogReg  <= 1'b0;
            dirReg    <= 1'b0;
            flagEn    <= '0;
        end else begin
            resultReg <= resultNext;
            doneReg   <= doneNext;
            busyReg   <= busyNext;
            carryReg  <= carryNext;
            zeroReg   <= zeroNext;
            signReg   <= signNext;
            if (accept) begin
                isLogReg <= bus.isLog;
                dirReg   <= bus.dir;
                flagEn   <= bus.flagSwitch;
                shReg    <= opResult;
                lastOut  <= opCarry;
                count    <= (bus.opSwitch == OP_SHIFT) ? shamt : '0;
            end else if (state == SHIFT) begin
                shReg   <= shNext;
                lastOut <= shOut;
                count   <= count - SHAMT_W'(1);
            end
        end
    end

    assign bus.result = resultReg;
    assign bus.done   = doneReg;
    assign bus.busy   = busyReg;
    assign bus.carry  = carryReg;
    assign bus.zero   = zeroReg;
    assign bus.sign   = signReg;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases plus random ops, scoreboarded against an arithmetic model.
module tb_alu_exec_unit;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    int   busyCnt = 0;
    logic mC = 1'b0;
    logic mZ = 1'b0;
    logic mS = 1'b0;

    typedef struct {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        s;
        int          lat;
        int          acc;
    } expT;

    expT expQ[$];

    alu_exec_unit_if #(.WIDTH(32)) bus ();

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic on the operands, no bit-serial emulation.
    task automatic model(input logic [2:0] op, input logic lg, input logic dr,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic c, output int lat);
        logic [32:0] s;
        int n;
        int idx;
        r   = a;
        c   = 1'b0;
        lat = 1;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32]; end
            3'd1: begin r = 32'd0 - b; c = (b == 32'd0); end
            3'd2: r = a & b;
            3'd3: r = a ^ b;
            3'd4: begin
                n   = int'(b[4:0]);
                lat = n + 1;
                if (n > 0) begin
                    if (!dr) begin
                        r   = a << n;
                        idx = 32 - n;
                        c   = a[idx];
                    end else begin
                        r   = lg ? (a >> n) : 32'($signed(a) >>> n);
                        idx = n - 1;
                        c   = a[idx];
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic lg, input logic dr,
                         input logic [2:0] fs, input logic [31:0] a, input logic [31:0] b);
        expT e;
        @(negedge clk);
        bus.opSwitch   = op;
        bus.isLog      = lg;
        bus.dir        = dr;
        bus.flagSwitch = fs;
        bus.srcA       = a;
        bus.srcB       = b;
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        model(op, lg, dr, a, b, e.r, e.c, e.lat);
        if (fs[0]) mC = e.c;
        if (fs[1]) mZ = (e.r == 32'd0);
        if (fs[2]) mS = e.r[31];
        e.c   = mC;
        e.z   = mZ;
        e.s   = mS;
        e.acc = cyc;
        expQ.push_back(e);
        bus.start      = 1'b0;
        bus.opSwitch   = 3'($urandom);
        bus.isLog      = 1'($urandom);
        bus.dir        = 1'($urandom);
        bus.flagSwitch = 3'($urandom);
        bus.srcA       = $urandom;
        bus.srcB       = $urandom;
    endtask

    task automatic waitDone(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL %s: done not seen within 40 cycles, required a done pulse", name);
            expQ.delete();
        end
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic lg, input logic dr,
                       input logic [2:0] fs, input logic [31:0] a, input logic [31:0] b);
        issue(op, lg, dr, fs, a, b);
        waitDone(name);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            busyCnt = 0;
        end else begin
            if (bus.busy) busyCnt++;
            if (bus.done) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL spurious_done: got done=1 with no outstanding op, required 0");
                end else begin
                    expT e;
                    e = expQ.pop_front();
                    check("result", bus.result, e.r);
                    check("carry", 32'(bus.carry), 32'(e.c));
                    check("zero", 32'(bus.zero), 32'(e.z));
                    check("sign", 32'(bus.sign), 32'(e.s));
                    check("latency", 32'(cyc - e.acc), 32'(e.lat));
                    check("busy_cycles", 32'(busyCnt), 32'(e.lat - 1));
                end
                busyCnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.opSwitch   = 3'd0;
        bus.isLog      = 1'b0;
        bus.dir        = 1'b0;
        bus.flagSwitch = 3'd0;
        bus.srcA       = 32'd0;
        bus.srcB       = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_result", bus.result, 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_carry", 32'(bus.carry), 32'd0);
        check("rst_zero", 32'(bus.zero), 32'd0);
        check("rst_sign", 32'(bus.sign), 32'd0);
        reset = 1'b1;

        run("add_wrap", 3'd0, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'd1);
        run("asr5", 3'd4, 1'b0, 1'b1, 3'b111, 32'h8000_0010, 32'd5);
        run("lsl31", 3'd4, 1'b1, 1'b0, 3'b111, 32'd3, 32'd31);
        run("shift0", 3'd4, 1'b1, 1'b0, 3'b111, 32'h1234_5678, 32'hABCD_EF20);
        run("add_cs", 3'd0, 1'b0, 1'b0, 3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("comp0", 3'd1, 1'b0, 1'b0, 3'b010, 32'h5555_AAAA, 32'd0);
        run("comp5", 3'd1, 1'b0, 1'b0, 3'b101, 32'h0, 32'd5);

        // AND start pulsed mid-shift must be dropped.
        issue(3'd4, 1'b1, 1'b0, 3'b111, 32'h0000_0F0F, 32'd20);
        repeat (5) @(negedge clk);
        bus.opSwitch = 3'd2;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        waitDone("shift20_ignore");

        // Start presented in the done cycle must be dropped.
        issue(3'd3, 1'b0, 1'b0, 3'b111, 32'hAAAA_0000, 32'h0000_5555);
        waitDone("xor_pre");
        bus.opSwitch = 3'd2;
        bus.srcA     = 32'hFFFF_FFFF;
        bus.srcB     = 32'hFFFF_FFFF;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-shift aborts the op and clears outputs at once.
        run("set_flags", 3'd0, 1'b0, 1'b0, 3'b111, 32'h8000_0000, 32'h8000_0001);
        issue(3'd4, 1'b1, 1'b1, 3'b111, 32'hDEAD_BEEF, 32'd10);
        repeat (4) @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("abort_result", bus.result, 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_carry", 32'(bus.carry), 32'd0);
        check("abort_sign", 32'(bus.sign), 32'd0);
        expQ.delete();
        mC = 1'b0;
        mZ = 1'b0;
        mS = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        run("xor_after_rst", 3'd3, 1'b0, 1'b0, 3'b111, 32'hF0F0_F0F0, 32'hFF00_FF00);

        for (int k = 0; k < 300; k++) begin
            logic [2:0] op;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b[4:0] = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
            run("random", op, 1'($urandom), 1'($urandom), 3'($urandom), $urandom, b);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
